imm_gen_stage: RTL and testbench

IMM_GEN_STAGE -- requirements
Module: imm_gen_stage

---
 rtl/imm_gen_stage.sv | 166 ++++++++++++++++
 tb/tb_imm_gen_stage.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_stage.sv
// RISC-V immediate decode into a 2-entry skid buffer; 1-cycle latency, in_ready from occupancy only (deasserts when FULL).
// Optional IMMGEN_TARGET_EN adds a per-entry pc+imm target (JALR target excludes rs1).
module imm_gen_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            jump
`ifdef IMMGEN_TARGET_EN
    ,
    output logic [XLEN-1:0] target
`endif
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_stage: XLEN must be 32 or 64");
    end

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            jump;
        logic [XLEN-1:0] pc;
`ifdef IMMGEN_TARGET_EN
        logic [XLEN-1:0] target;
`endif
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state_q, state_d;
    entry_t head_q, tail_q, dec;
    logic signed [31:0] raw;
    logic push, pop;

    // Each format is sign-extended to 32 bits first, then widened to XLEN.
    always_comb begin
        raw      = '0;
        dec      = '0;
        dec.pc   = pc;
        case (instr[6:0])
            7'b0110111, 7'b0010111: begin
                dec.fmt = FMT_U;
                raw     = {instr[31:12], 12'b0};
            end
            7'b1101111: begin
                dec.fmt  = FMT_J;
                dec.jump = 1'b1;
                raw      = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            7'b1100111: begin
                dec.fmt  = FMT_I;
                dec.jump = 1'b1;
                raw      = {{20{instr[31]}}, instr[31:20]};
            end
            7'b0000011, 7'b0010011: begin
                dec.fmt = FMT_I;
                raw     = {{20{instr[31]}}, instr[31:20]};
            end
            7'b0100011: begin
                dec.fmt = FMT_S;
                raw     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            7'b1100011: begin
                dec.fmt = FMT_B;
                raw     = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            default: begin
                dec.fmt = FMT_NONE;
                raw     = '0;
            end
        endcase
        dec.imm = XLEN'(raw);
`ifdef IMMGEN_TARGET_EN
        dec.target = pc + dec.imm;
`endif
    end

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY:   if (push) state_d = ONE;
                ONE: begin
                    if (push && !pop)      state_d = FULL;
                    else if (pop && !push) state_d = EMPTY;
                end
                FULL:    if (pop) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state_q != FULL);
        out_valid = (state_q != EMPTY);
        imm       = out_valid ? head_q.imm  : '0;
        fmt       = out_valid ? head_q.fmt  : FMT_NONE;
        jump      = out_valid ? head_q.jump : 1'b0;
`ifdef IMMGEN_TARGET_EN
        target    = out_valid ? head_q.target : '0;
`endif
    end

    // Head always holds the oldest entry; a simultaneous push/pop in ONE replaces it directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
        end else if (flush) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            case (state_q)
                EMPTY: if (push) head_q <= dec;
                ONE: begin
                    if (push && pop) head_q <= dec;
                    else if (push)   tail_q <= dec;
                end
                FULL: if (pop) begin
                    head_q <= tail_q;
                    tail_q <= '0;
                end
                default: ;
            endcase
        end
    end

    // Stored pc has no consumer on the output side; target is computed at push.
    logic unused_pc;
    assign unused_pc = ^head_q.pc;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: decode vectors, skid-buffer ordering, flush and async reset.
module tb_imm_gen_stage;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] instr, pc;
    logic        in_ready, out_valid, jump;
    logic [31:0] imm;
    logic [2:0]  fmt;
`ifdef IMMGEN_TARGET_EN
    logic [31:0] target;
    logic [63:0] target64;
`endif

    logic        in_valid64, out_ready64, flush64;
    logic [31:0] instr64;
    logic [63:0] pc64, imm64;
    logic        in_ready64, out_valid64, jump64;
    logic [2:0]  fmt64;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .out_valid(out_valid), .out_ready(out_ready),
        .imm(imm), .fmt(fmt), .jump(jump)
`ifdef IMMGEN_TARGET_EN
        , .target(target)
`endif
    );

    imm_gen_stage #(.XLEN(64)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush64), .in_valid(in_valid64), .in_ready(in_ready64),
        .instr(instr64), .pc(pc64), .out_valid(out_valid64), .out_ready(out_ready64),
        .imm(imm64), .fmt(fmt64), .jump(jump64)
`ifdef IMMGEN_TARGET_EN
        , .target(target64)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b0) begin
            checks++;
            if (imm !== 32'h0 || fmt !== 3'd0 || jump !== 1'b0) begin
                failures++;
                $error("FAIL idle32 outputs not zero imm=0x%0h fmt=%0d jump=%0b", imm, fmt, jump);
            end
        end
        if (rst_n === 1'b1 && out_valid64 === 1'b0) begin
            checks++;
            if (imm64 !== 64'h0 || fmt64 !== 3'd0 || jump64 !== 1'b0) begin
                failures++;
                $error("FAIL idle64 outputs not zero imm=0x%0h fmt=%0d jump=%0b", imm64, fmt64, jump64);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic single(input string tag, input logic [31:0] i, input logic [31:0] p,
                          input logic [31:0] e_imm, input logic [2:0] e_fmt, input logic e_jump);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        instr     = i;
        pc        = p;
        step();
        in_valid  = 1'b0;
        check({tag, ".valid"}, out_valid, 1'b1);
        check({tag, ".imm"},   imm,       e_imm);
        check({tag, ".fmt"},   fmt,       e_fmt);
        check({tag, ".jump"},  jump,      e_jump);
`ifdef IMMGEN_TARGET_EN
        check({tag, ".target"}, target, 32'(p + e_imm));
`endif
        step();
        check({tag, ".drained"}, out_valid, 1'b0);
        check({tag, ".imm_zero"}, imm, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = '0; pc = '0;
        flush64 = 1'b0; in_valid64 = 1'b0; out_ready64 = 1'b1; instr64 = '0; pc64 = '0;

        #2;
        check("rst.out_valid", out_valid, 1'b0);
        check("rst.imm",       imm,       32'h0);
        check("rst.fmt",       fmt,       3'd0);
        check("rst.jump",      jump,      1'b0);
        step();
        step();
        rst_n = 1'b1;
        step();
        check("post_rst.in_ready", in_ready, 1'b1);
        check("post_rst.out_valid", out_valid, 1'b0);

        // beq x0,x0,-4 encodes as 0xFE000EE3.
        single("beq_m4", 32'hFE000EE3, 32'h200, 32'hFFFFFFFC, 3'd3, 1'b0);
        // 0xFE000FE3: instr[11:8]=1111 so the B immediate is -2.
        single("beq_fe3", 32'hFE000FE3, 32'h200, 32'hFFFFFFFE, 3'd3, 1'b0);
        single("jal_p8", 32'h0080006F, 32'h100, 32'h00000008, 3'd5, 1'b1);
        single("jalr_12", 32'h00C080E7, 32'h40, 32'h0000000C, 3'd1, 1'b1);
        single("sw_m4", 32'hFE112E23, 32'h0, 32'hFFFFFFFC, 3'd2, 1'b0);
        single("auipc", 32'h12345097, 32'h1000, 32'h12345000, 3'd4, 1'b0);
        single("rtype_none", 32'h00000033, 32'h300, 32'h0, 3'd0, 1'b0);

        // XLEN=64 instance
        in_valid64 = 1'b1; instr64 = 32'hFFF02083; pc64 = 64'h1000;
        step();
        in_valid64 = 1'b0;
        check("x64.lw.valid", out_valid64, 1'b1);
        check("x64.lw.imm",   imm64, 64'hFFFFFFFFFFFFFFFF);
        check("x64.lw.fmt",   fmt64, 3'd1);
        check("x64.lw.jump",  jump64, 1'b0);
`ifdef IMMGEN_TARGET_EN
        check("x64.lw.target", target64, 64'h0FFF);
`endif
        step();
        in_valid64 = 1'b1; instr64 = 32'h123450B7;
        step();
        in_valid64 = 1'b0;
        check("x64.lui.imm", imm64, 64'h0000000012345000);
        check("x64.lui.fmt", fmt64, 3'd4);
        check("x64.in_ready", in_ready64, 1'b1);
        step();

        // Back-pressure: three pushes with out_ready low
        out_ready = 1'b0;
        in_valid = 1'b1; instr = 32'h00100093; pc = 32'h0;
        check("skid.rdy0", in_ready, 1'b1);
        step();
        instr = 32'h00200093;
        check("skid.rdy1", in_ready, 1'b1);
        check("skid.head_a", imm, 32'h1);
        step();
        instr = 32'h00300093;
        check("skid.rdy_full", in_ready, 1'b0);
        step();
        check("skid.rdy_held", in_ready, 1'b0);
        check("skid.stable_imm", imm, 32'h1);
        check("skid.stable_fmt", fmt, 3'd1);
        out_ready = 1'b1;
        step();
        check("skid.out_b", imm, 32'h2);
        check("skid.rdy_reopen", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        check("skid.out_c", imm, 32'h3);
        check("skid.valid_c", out_valid, 1'b1);
        step();
        check("skid.empty", out_valid, 1'b0);

        // Flush while FULL with an offer present
        out_ready = 1'b0;
        in_valid = 1'b1; instr = 32'h00100093;
        step();
        instr = 32'h00200093;
        step();
        instr = 32'h00300093; flush = 1'b1;
        check("flush.full", in_ready, 1'b0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush.valid", out_valid, 1'b0);
        check("flush.rdy", in_ready, 1'b1);
        out_ready = 1'b1;
        step();
        check("flush.no_emit", out_valid, 1'b0);

        // Flush in ONE discards the concurrent push
        out_ready = 1'b0;
        in_valid = 1'b1; instr = 32'h00100093;
        step();
        instr = 32'h00200093; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush1.valid", out_valid, 1'b0);
        step();
        check("flush1.no_emit", out_valid, 1'b0);

        // Asynchronous reset mid-cycle while FULL
        in_valid = 1'b1; instr = 32'h00100093;
        step();
        instr = 32'h00200093;
        step();
        in_valid = 1'b0;
        check("areset.pre_full", in_ready, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset.valid", out_valid, 1'b0);
        check("areset.imm", imm, 32'h0);
        check("areset.rdy", in_ready, 1'b1);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        check("areset.no_survivor", out_valid, 1'b0);
        single("post_areset", 32'h0080006F, 32'h100, 32'h00000008, 3'd5, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
